// File: rtl/doorlock_pkg.sv
// doorlock_pkg: shared definitions for the door-lock authentication controller.
//   state_t            : FSM state encoding (IDLE/UNLOCKED/LOCKOUT/SET_PW)
//   DEF_*              : default timing / retry constants
//   timer_width()      : width of the shared dwell timer for a parameter set
package doorlock_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_UNLOCKED = 2'd1,
    S_LOCKOUT  = 2'd2,
    S_SETPW    = 2'd3
  } state_t;

  localparam int unsigned DEF_MAX_FAIL       = 3;
  localparam int unsigned DEF_UNLOCK_CYCLES  = 1000;
  localparam int unsigned DEF_LOCKOUT_CYCLES = 5000;

  // The timer only ever holds N-1 for the larger dwell, so $clog2 of that
  // dwell suffices; clamp to one bit so single-cycle dwells still elaborate.
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b);
    int unsigned m;
    int unsigned w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/doorlock_timer.sv
// doorlock_timer: loadable down-counter used as the FSM dwell timer.
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset (count -> 0)
//   load     in   load load_val this cycle (takes priority over counting)
//   load_val in   value to load
//   zero     out  count is 0
// The count stops at 0 rather than wrapping.
module doorlock_timer #(
  parameter int unsigned WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/doorlock_ctrl.sv
// doorlock_ctrl: authentication controller downstream of the password
// comparators. Grants timed unlocks, counts consecutive failures into a timed
// lockout, honours a master override and runs the password-change sequence.
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   confirm     in   user confirm; each 0->1 transition is one event
//   same        in   entry matches user password (valid while confirm high)
//   master_same in   entry matches master password (valid while confirm high)
//   change_req  in   level; request password change on a correct entry
//   unlocked    out  door open
//   lockout     out  entry disabled
//   set_mode    out  awaiting new password
//   ans_we      out  one-cycle strobe: store current entry as user password
//   fail_count  out  consecutive failed entries
module doorlock_ctrl
  import doorlock_pkg::*;
#(
  parameter int unsigned MAX_FAIL       = DEF_MAX_FAIL,
  parameter int unsigned UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          confirm,
  input  logic                          same,
  input  logic                          master_same,
  input  logic                          change_req,
  output logic                          unlocked,
  output logic                          lockout,
  output logic                          set_mode,
  output logic                          ans_we,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_count
);

  localparam int unsigned FCW = $clog2(MAX_FAIL + 1);
  localparam int unsigned TW  = timer_width(UNLOCK_CYCLES, LOCKOUT_CYCLES);

  localparam logic [TW-1:0]  UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0]  LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [FCW-1:0] FAIL_LIMIT   = FCW'(MAX_FAIL);

  state_t         state_q, state_d;
  logic [FCW-1:0] fail_q, fail_d, fail_inc;
  logic           confirm_q;
  logic           ev_q, same_q, master_q, change_q;
  logic           we_d;
  logic           t_load, t_zero;
  logic [TW-1:0]  t_load_val;

  // The event and the comparator results are captured together on the edge
  // that samples the confirm rising edge, so the FSM acts one edge later on a
  // consistent snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      confirm_q <= 1'b0;
      ev_q      <= 1'b0;
      same_q    <= 1'b0;
      master_q  <= 1'b0;
      change_q  <= 1'b0;
    end else begin
      confirm_q <= confirm;
      ev_q      <= confirm & ~confirm_q;
      same_q    <= same;
      master_q  <= master_same;
      change_q  <= change_req;
    end
  end

  assign fail_inc = fail_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    fail_d     = fail_q;
    we_d       = 1'b0;
    t_load     = 1'b0;
    t_load_val = '0;
    unique case (state_q)
      S_IDLE: begin
        if (ev_q) begin
          if (master_q) begin
            state_d    = S_UNLOCKED;
            fail_d     = '0;
            t_load     = 1'b1;
            t_load_val = UNLOCK_LOAD;
          end else if (same_q && change_q) begin
            state_d    = S_SETPW;
            fail_d     = '0;
            t_load     = 1'b1;
            t_load_val = UNLOCK_LOAD;
          end else if (same_q) begin
            state_d    = S_UNLOCKED;
            fail_d     = '0;
            t_load     = 1'b1;
            t_load_val = UNLOCK_LOAD;
          end else if (fail_inc == FAIL_LIMIT) begin
            state_d    = S_LOCKOUT;
            fail_d     = '0;
            t_load     = 1'b1;
            t_load_val = LOCKOUT_LOAD;
          end else begin
            fail_d = fail_inc;
          end
        end
      end
      S_UNLOCKED: begin
        if (t_zero) state_d = S_IDLE;
      end
      S_LOCKOUT: begin
        if ((ev_q && master_q) || t_zero) state_d = S_IDLE;
      end
      S_SETPW: begin
        // A confirm landing on the expiry cycle still commits the write.
        if (ev_q) begin
          we_d    = 1'b1;
          state_d = S_IDLE;
        end else if (t_zero) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  doorlock_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_load_val),
    .zero     (t_zero)
  );

  // Outputs decode the next state so they track the state register exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      fail_q   <= '0;
      unlocked <= 1'b0;
      lockout  <= 1'b0;
      set_mode <= 1'b0;
      ans_we   <= 1'b0;
    end else begin
      state_q  <= state_d;
      fail_q   <= fail_d;
      unlocked <= (state_d == S_UNLOCKED);
      lockout  <= (state_d == S_LOCKOUT);
      set_mode <= (state_d == S_SETPW);
      ans_we   <= we_d;
    end
  end

  assign fail_count = fail_q;

endmodule
